alu_multicycle: RTL and testbench
=================================

# alu_multicycle

Parametrised, registered successor to the team's single-cycle combinational ALU. It executes the existing logic and arithmetic operations, plus shifts, signed/unsigned set-less-than and an iterative shift-add multiply, behind a start/valid handshake. It sits in the execute stage of the multicycle datapath. The control unit stalls on `busy_o` and captures `result_o` when `valid_o` is high.

## Interface
- `WIDTH`, default 32: operand/result width. Must be a power of two, at least 4.
- `SHW`, default `$clog2(WIDTH)`: shift-amount width. Derived; never overridden.

Ports:
- `clk_i`  in  1  clock. All state changes on its rising edge.
- `rst_i`  in  1  reset. Synchronous, active-high.
- `start_i`  in  1  request. Accepted only when `busy_o`=0.
- `src1_i`  in  WIDTH  operand A. Sampled at accept.
- `src2_i`  in  WIDTH  operand B. Sampled at accept.
- `ctrl_i`  in  4  operation code. Sampled at accept.
- `busy_o`  out  1  high while a multiply is iterating.
- `valid_o`  out  1  one-cycle pulse; `result_o`, `zero_o` and `overflow_o` are new.
- `result_o`  out  WIDTH  registered result. Holds its value until the next `valid_o`.
- `zero_o`  out  1  registered; equals (`result_o` == 0).
- `overflow_o`  out  1  registered; signed overflow for ADD/SUB, 0 for all other ops.

## Operation
- Op codes:
  - 0 AND; 1 OR; 2 ADD; 6 SUB; 12 NOR.
  - 7 SLT (signed): result 1 if A<B as two's complement, else 0.
  - 13 SLTU: unsigned compare, same result encoding.
  - 3 SLL: A << B[SHW-1:0]. 4 SRL: logical right shift by the same amount. 5 SRA: arithmetic right shift by the same amount.
  - 8 MUL: low WIDTH bits of A×B. Signedness is irrelevant for the low half.
  - Any other code: result 0, overflow 0. Still completes with latency 1.
- Overflow:
  - ADD: set when A[msb]==B[msb] and sum[msb]!=A[msb].
  - SUB: set when A[msb]!=B[msb] and diff[msb]!=A[msb].
  - Wrap-around result is always delivered; there is no saturation.
- State machine IDLE, MUL:
  - IDLE: on accept of a non-MUL op, latch the result and pulse `valid_o` next cycle. Stay in IDLE.
  - IDLE: on accept of MUL, load multiplicand=A, multiplier=B, accumulator=0, count=0. Go to MUL.
  - MUL: each cycle, if multiplier[0] then accumulator += multiplicand. Then multiplicand <<= 1, multiplier >>= 1, count++.
  - MUL: after WIDTH iterations, write the accumulator to `result_o`, pulse `valid_o`, return to IDLE.
- `start_i` while `busy_o`=1 is ignored. No queuing; the operands are discarded.
- `result_o`, `zero_o` and `overflow_o` change only on the edge that raises `valid_o`.

## Timing
- Reset values: `busy_o`=0, `valid_o`=0, `result_o`=0, `zero_o`=1, `overflow_o`=0. State=IDLE.
- Accept edge is E (`start_i`=1, `busy_o`=0).
- Non-MUL ops: `valid_o`=1 in the cycle after E. Latency 1; one op per cycle when `start_i` is held high with new operands.
- MUL:
  - `busy_o`=1 from E+1 through E+WIDTH.
  - `valid_o`=1 in cycle E+WIDTH+1, with `busy_o`=0 in that cycle.
  - Latency is WIDTH+1; 33 for the default.
- Back-to-back: in the cycle `valid_o`=1, `busy_o`=0, so a new `start_i` is accepted on that edge.
- `rst_i`=1 on any edge, including mid-multiply:
  - Aborts the operation and restores the reset values on that edge.
  - No `valid_o` is produced for the aborted op.
  - `rst_i` has priority over `start_i`.
- `valid_o` is never high for two consecutive cycles from a single accept.

## Test plan
- Reset then ADD: assert `rst_i` for 2 cycles, then check `result_o`=0, `zero_o`=1. Issue ADD 0x7FFFFFFF+1 → next cycle `valid_o`=1, `result_o`=0x80000000, `overflow_o`=1, `zero_o`=0.
- SUB, SLT, SLTU: SUB 5−5 → 0, `zero_o`=1. SLT 0xFFFFFFFF vs 1 → 1. SLTU 0xFFFFFFFF vs 1 → 0. Issue the three back-to-back; expect three consecutive `valid_o` pulses.
- Shifts: SRA 0x80000000 by 31 → 0xFFFFFFFF. SRL by 31 → 1. SLL 1 by 0x25 → 0x20, since only the low 5 bits of the amount are used. Also check NOR 0,0 → 0xFFFFFFFF and code 15 → 0.
- MUL: 0x0001_0003 × 0x0002_0005 → 0x000B_000F. Check `busy_o` high for 32 cycles and `valid_o` at cycle 33. Check 0xFFFFFFFF×0xFFFFFFFF → 0x00000001.
- Ignored start: pulse `start_i` with ADD at cycle 10 of a MUL → no extra `valid_o`, and the MUL result is unchanged.
- Reset mid-MUL: assert `rst_i` at cycle 15 → `busy_o`=0 and `result_o`=0 next cycle. No `valid_o` within the following 40 cycles.

Source files
------------

// File: rtl/alu_multicycle.sv
// Registered ALU with start/valid handshake: single-cycle logic/arith/shift/compare ops
// and an iterative shift-add multiply that holds busy_o while it runs.
module alu_multicycle #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic [3:0]       ctrl_i,
    output logic             busy_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             overflow_o
);

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SLL  = 4'd3;
    localparam logic [3:0] OP_SRL  = 4'd4;
    localparam logic [3:0] OP_SRA  = 4'd5;
    localparam logic [3:0] OP_SUB  = 4'd6;
    localparam logic [3:0] OP_SLT  = 4'd7;
    localparam logic [3:0] OP_MUL  = 4'd8;
    localparam logic [3:0] OP_NOR  = 4'd12;
    localparam logic [3:0] OP_SLTU = 4'd13;

    localparam int              MSB  = WIDTH - 1;
    localparam logic [SHW-1:0]  LAST = SHW'(WIDTH - 1);

    typedef enum logic [0:0] {S_IDLE, S_MUL} state_t;

    state_t state, state_next;

    logic             op_done;
    logic             mul_load;
    logic             mul_done;

    logic [WIDTH-1:0] alu_result;
    logic             alu_ovf;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [SHW-1:0]   shamt;

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [SHW-1:0]   count;

    assign sum    = src1_i + src2_i;
    assign diff   = src1_i - src2_i;
    assign shamt  = src2_i[SHW-1:0];
    assign busy_o = (state == S_MUL);

    // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        alu_result = '0;
        alu_ovf    = 1'b0;
        unique case (ctrl_i)
            OP_AND:  alu_result = src1_i & src2_i;
            OP_OR:   alu_result = src1_i | src2_i;
            OP_NOR:  alu_result = ~(src1_i | src2_i);
            OP_ADD: begin
                alu_result = sum;
                alu_ovf    = (src1_i[MSB] == src2_i[MSB]) && (sum[MSB] != src1_i[MSB]);
            end
            OP_SUB: begin
                alu_result = diff;
                alu_ovf    = (src1_i[MSB] != src2_i[MSB]) && (diff[MSB] != src1_i[MSB]);
            end
            OP_SLT:  alu_result = {{(WIDTH-1){1'b0}}, ($signed(src1_i) < $signed(src2_i))};
            OP_SLTU: alu_result = {{(WIDTH-1){1'b0}}, (src1_i < src2_i)};
            OP_SLL:  alu_result = src1_i << shamt;
            OP_SRL:  alu_result = src1_i >> shamt;
            OP_SRA:  alu_result = $unsigned($signed(src1_i) >>> shamt);
            default: alu_result = '0;
        endcase
    end

    always_comb begin
        state_next = state;
        op_done    = 1'b0;
        mul_load   = 1'b0;
        mul_done   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start_i) begin
                    if (ctrl_i == OP_MUL) begin
                        mul_load   = 1'b1;
                        state_next = S_MUL;
                    end else begin
                        op_done = 1'b1;
                    end
                end
            end
            S_MUL: begin
                if (count == LAST) begin
                    mul_done   = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // The final iteration's partial product is folded in here so the result is ready on the last busy edge.
    assign acc_next = acc + (mplier[0] ? mcand : '0);

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_o    <= 1'b0;
            result_o   <= '0;
            zero_o     <= 1'b1;
            overflow_o <= 1'b0;
            mcand      <= '0;
            mplier     <= '0;
            acc        <= '0;
            count      <= '0;
        end else begin
            valid_o <= op_done | mul_done;
            if (op_done) begin
                result_o   <= alu_result;
                zero_o     <= (alu_result == '0);
                overflow_o <= alu_ovf;
            end
            if (mul_load) begin
                mcand  <= src1_i;
                mplier <= src2_i;
                acc    <= '0;
                count  <= '0;
            end else if (state == S_MUL) begin
                acc    <= acc_next;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                count  <= count + 1'b1;
            end
            if (mul_done) begin
                result_o   <= acc_next;
                zero_o     <= (acc_next == '0);
                overflow_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle: table of single-cycle ops issued back-to-back,
// then hand-written multiply, ignored-start and reset-abort sequences.
module tb_alu_multicycle;

    localparam int WIDTH = 32;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             start_i;
    logic [WIDTH-1:0] src1_i;
    logic [WIDTH-1:0] src2_i;
    logic [3:0]       ctrl_i;
    logic             busy_o;
    logic             valid_o;
    logic [WIDTH-1:0] result_o;
    logic             zero_o;
    logic             overflow_o;

    int checks   = 0;
    int failures = 0;

    alu_multicycle #(.WIDTH(WIDTH)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .src1_i     (src1_i),
        .src2_i     (src2_i),
        .ctrl_i     (ctrl_i),
        .busy_o     (busy_o),
        .valid_o    (valid_o),
        .result_o   (result_o),
        .zero_o     (zero_o),
        .overflow_o (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        zero;
        logic        ovf;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Packs {busy, valid, zero, ovf, result} for a single compare.
    function automatic logic [63:0] pack(input logic b, input logic v, input logic z,
                                         input logic o, input logic [31:0] r);
        return {28'd0, b, v, z, o, r};
    endfunction

    task automatic drive(input logic s, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        start_i = s;
        ctrl_i  = op;
        src1_i  = a;
        src2_i  = b;
    endtask

    // Runs one multiply: busy must hold for 32 cycles with no valid, valid arrives at cycle 33.
    // If ign_cycle is nonzero, an ADD start pulse is driven during that busy cycle.
    task automatic run_mul(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp, input int ign_cycle);
        int busy_cnt;
        int valid_cnt;
        @(negedge clk_i);
        drive(1'b1, 4'd8, a, b);
        busy_cnt  = 0;
        valid_cnt = 0;
        for (int c = 1; c <= 32; c++) begin
            @(negedge clk_i);
            if (c == ign_cycle) drive(1'b1, 4'd2, 32'd1, 32'd1);
            else                drive(1'b0, 4'd0, 32'd0, 32'd0);
            if (busy_o)  busy_cnt++;
            if (valid_o) valid_cnt++;
        end
        check({name, "_busy_cycles"}, 64'(busy_cnt), 64'd32);
        check({name, "_early_valid"}, 64'(valid_cnt), 64'd0);
        @(negedge clk_i);
        check({name, "_done"}, pack(busy_o, valid_o, zero_o, overflow_o, result_o),
              pack(1'b0, 1'b1, (exp == 32'd0), 1'b0, exp));
        @(negedge clk_i);
        check({name, "_single_pulse"}, pack(busy_o, valid_o, zero_o, overflow_o, result_o),
              pack(1'b0, 1'b0, (exp == 32'd0), 1'b0, exp));
    endtask

    vec_t vecs[$];

    initial begin
        int busy_cnt;
        int valid_cnt;

        vecs.push_back('{"add_ovf",  4'd2,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1});
        vecs.push_back('{"sub_zero", 4'd6,  32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0});
        vecs.push_back('{"slt",      4'd7,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0});
        vecs.push_back('{"sltu",     4'd13, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0});
        vecs.push_back('{"sra31",    4'd5,  32'h8000_0000, 32'd31,        32'hFFFF_FFFF, 1'b0, 1'b0});
        vecs.push_back('{"srl31",    4'd4,  32'h8000_0000, 32'd31,        32'h0000_0001, 1'b0, 1'b0});
        vecs.push_back('{"sll_mask", 4'd3,  32'h0000_0001, 32'h0000_0025, 32'h0000_0020, 1'b0, 1'b0});
        vecs.push_back('{"nor",      4'd12, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0});
        vecs.push_back('{"op15",     4'd15, 32'h0000_1234, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0});
        vecs.push_back('{"and",      4'd0,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0});
        vecs.push_back('{"or",       4'd1,  32'h0F0F_0000, 32'h0000_00F0, 32'h0F0F_00F0, 1'b0, 1'b0});
        vecs.push_back('{"sub_ovf",  4'd6,  32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1});
        vecs.push_back('{"add_wrap", 4'd2,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0});
        vecs.push_back('{"slt_neg",  4'd7,  32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0});
        vecs.push_back('{"sra_pos",  4'd5,  32'h4000_0000, 32'd4,         32'h0400_0000, 1'b0, 1'b0});

        rst_i = 1'b1;
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        check("reset_state", pack(busy_o, valid_o, zero_o, overflow_o, result_o),
              pack(1'b0, 1'b0, 1'b1, 1'b0, 32'd0));

        // Each vector is checked in the cycle after it is driven while the next is driven,
        // so every pulse must be valid with no gaps.
        for (int i = 0; i <= vecs.size(); i++) begin
            if (i > 0) begin
                check(vecs[i-1].name, pack(busy_o, valid_o, zero_o, overflow_o, result_o),
                      pack(1'b0, 1'b1, vecs[i-1].zero, vecs[i-1].ovf, vecs[i-1].res));
            end
            if (i < vecs.size()) drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b);
            else                 drive(1'b0, 4'd0, 32'd0, 32'd0);
            @(negedge clk_i);
        end
        check("idle_hold", pack(busy_o, valid_o, zero_o, overflow_o, result_o),
              pack(1'b0, 1'b0, 1'b0, 1'b0, 32'h0400_0000));

        run_mul("mul_basic", 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 0);
        run_mul("mul_ones",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 0);
        run_mul("mul_ign",   32'd7,         32'd6,         32'd42,        10);

        // Reset at busy cycle 15 of a multiply whose operands would give a nonzero product.
        @(negedge clk_i);
        drive(1'b1, 4'd8, 32'd3, 32'd5);
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk_i);
            drive(1'b0, 4'd0, 32'd0, 32'd0);
        end
        check("mid_mul_busy", 64'(busy_o), 64'd1);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        check("mul_abort", pack(busy_o, valid_o, zero_o, overflow_o, result_o),
              pack(1'b0, 1'b0, 1'b1, 1'b0, 32'd0));
        busy_cnt  = 0;
        valid_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk_i);
            if (valid_o) valid_cnt++;
            if (busy_o)  busy_cnt++;
        end
        check("abort_no_valid", 64'(valid_cnt), 64'd0);
        check("abort_no_busy",  64'(busy_cnt),  64'd0);

        // Multiply right after an ADD completes confirms back-to-back accept on the valid edge.
        @(negedge clk_i);
        drive(1'b1, 4'd2, 32'd2, 32'd3);
        @(negedge clk_i);
        check("add_before_mul", pack(busy_o, valid_o, zero_o, overflow_o, result_o),
              pack(1'b0, 1'b1, 1'b0, 1'b0, 32'd5));
        drive(1'b1, 4'd8, 32'd9, 32'd9);
        @(negedge clk_i);
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        check("mul_accepted_b2b", 64'(busy_o), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
